// File: rtl/hex_cmp_pkg.sv
// Shared types for the serial hex comparator.
// One digit slice is reused for every nibble of the operands.
package hex_cmp_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } cmp_state_t;

    typedef struct packed {
        logic e;
        logic l;
        logic g;
    } cmp_res_t;

endpackage

// File: rtl/digit_compare_slice.sv
// Combinational magnitude compare of one hex digit.
// Shared by the controller across all digit positions.
module digit_compare_slice
    import hex_cmp_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               eq,
    output logic               lt,
    output logic               gt
);

    assign eq = (a == b);
    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/serial_hex_compare_ctrl.sv
// Digit-serial WIDTH-bit comparator, MSB digit first, with
// e/l/g cascade inputs and valid/ready start and result ports.
module serial_hex_compare_ctrl
    import hex_cmp_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  bit EARLY_EXIT = 1'b1,
    localparam int NDIG       = WIDTH / DIGIT_W,
    localparam int CNT_W      = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             e,
    input  logic             l,
    input  logic             g,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             E,
    output logic             L,
    output logic             G,
    output logic [CNT_W-1:0] cycles,
    output logic             busy
);

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             diff_q, diff_d;
    cmp_res_t         casc_q, casc_d;
    cmp_res_t         dres_q, dres_d;
    cmp_res_t         res_q, res_d;

    logic [DIGIT_W-1:0] a_dig, b_dig;
    logic               s_eq, s_lt, s_gt;
    logic               accept, last;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == CNT_W'(i)) begin
                a_dig = a_q[i*DIGIT_W +: DIGIT_W];
                b_dig = b_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    digit_compare_slice u_slice (
        .a  (a_dig),
        .b  (b_dig),
        .eq (s_eq),
        .lt (s_lt),
        .gt (s_gt)
    );

    assign accept = (state_q == IDLE) && start_valid;
    assign last   = (idx_q == '0) || (EARLY_EXIT && !s_eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid) state_d = COMPARE;
            COMPARE: if (last)        state_d = DONE;
            DONE:    if (res_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == IDLE);
        res_valid   = (state_q == DONE);
        busy        = (state_q != IDLE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        diff_d   = diff_q;
        casc_d   = casc_q;
        dres_d   = dres_q;
        res_d    = res_q;
        if (accept) begin
            a_d    = a;
            b_d    = b;
            casc_d = '{e: e, l: l, g: g};
            idx_d  = CNT_W'(NDIG - 1);
            cnt_d  = '0;
            diff_d = 1'b0;
        end else if (state_q == COMPARE) begin
            cnt_d = cnt_q + 1'b1;
            // Only the most significant differing digit decides L/G.
            if (!s_eq && !diff_q) begin
                diff_d = 1'b1;
                dres_d = '{e: 1'b0, l: s_lt, g: s_gt};
            end
            if (last) begin
                res_d    = diff_d ? dres_d : casc_q;
                cycles_d = cnt_q + 1'b1;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            diff_q   <= 1'b0;
            casc_q   <= '0;
            dres_q   <= '0;
            res_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            diff_q   <= diff_d;
            casc_q   <= casc_d;
            dres_q   <= dres_d;
            res_q    <= res_d;
        end
    end

    assign E      = res_q.e;
    assign L      = res_q.l;
    assign G      = res_q.g;
    assign cycles = cycles_q;

endmodule
